// File: rtl/spi_sram_responder.sv
// SPI serial-SRAM target (READ 0x03 / WRITE 0x02, 16-bit address).
// Oversampled on clk; includes a preload port for program images.
module spi_sram_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 err_opcode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA_RD,
    S_DATA_WR,
    S_IGNORE
  } state_e;

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] AONE = ADDR_BITS'(1);

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        op_rd_q, op_rd_d;
  logic        err_q, err_d;

  logic [7:0]  mem_q [DEPTH];

  logic        cs_s, sclk_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_fall;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] addr_new;
  logic [15:0] a_inc;
  logic        spi_we;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

  assign busy       = (state_q != S_IDLE);
  assign miso_oe    = (state_q == S_DATA_RD);
  assign miso       = miso_q & miso_oe;
  assign err_opcode = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      op_rd_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      op_rd_q   <= op_rd_d;
      err_q     <= err_d;
    end
  end

  // SPI writes and preloads share one port; preload only when idle
  always_ff @(posedge clk) begin
    if (spi_we) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= rx_byte;
    end else if (load_en && (state_q == S_IDLE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    op_rd_d   = op_rd_q;
    err_d     = err_q;
    spi_we    = 1'b0;
    rx_byte   = {rx_q[6:0], mosi_s};
    addr_new  = {addr_q[15:8], rx_byte};
    a_inc     = addr_q;
    a_inc[ADDR_BITS-1:0] = addr_q[ADDR_BITS-1:0] + AONE;

    if ((state_q != S_IDLE) && cs_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise && (state_q != S_IDLE) && (state_q != S_IGNORE)) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte;
      end
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (byte_done) begin
            if (rx_byte == 8'h03) begin
              op_rd_d = 1'b1;
              state_d = S_ADDR_HI;
            end else if (rx_byte == 8'h02) begin
              op_rd_d = 1'b0;
              state_d = S_ADDR_HI;
            end else begin
              err_d   = 1'b1;
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_HI: begin
          if (byte_done) begin
            addr_d[15:8] = rx_byte;
            state_d      = S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (byte_done) begin
            addr_d = addr_new;
            if (op_rd_q) begin
              tx_d    = mem_q[addr_new[ADDR_BITS-1:0]];
              state_d = S_DATA_RD;
            end else begin
              state_d = S_DATA_WR;
            end
          end
        end
        S_DATA_RD: begin
          // next byte is staged at the 8th rise so its MSB goes out on the next fall
          if (byte_done) begin
            addr_d = a_inc;
            tx_d   = mem_q[a_inc[ADDR_BITS-1:0]];
          end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        S_DATA_WR: begin
          if (byte_done) begin
            spi_we = 1'b1;
            addr_d = a_inc;
          end
        end
        S_IGNORE: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- Synthesizable SPI serial-SRAM responder, the target side of the computer's SPI memory master. It emulates the external ROM/RAM chip for FPGA bring-up and closed-loop simulation.
- The host-side cs/sclk/mosi pins drive this block. Its miso drives the computer's miso input.
- Runs entirely on the system clock: SPI pins are oversampled and edge-detected, with no sclk-clocked flops.
- Implements 23LC-style READ (0x03) and WRITE (0x02) with 16-bit address and sequential auto-increment, plus a side load port for preloading program images.

Parameters:
- ADDR_BITS, 8, implemented memory depth is 2^ADDR_BITS bytes; upper address bits received over SPI are ignored.
- SYNC_STAGES, 2, synchroniser depth on cs_n/sclk/mosi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 4x sclk frequency.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  SPI chip select, active low.
- sclk  input  1  SPI clock, mode 0 (idle low).
- mosi  input  1  SPI data from master.
- miso  output  1  SPI data to master.
- miso_oe  output  1  high while the responder drives miso.
- load_en  input  1  preload write strobe.
- load_addr  input  ADDR_BITS  preload address.
- load_data  input  8  preload data.
- busy  output  1  high whenever the state is not IDLE.
- err_opcode  output  1  sticky flag: an unsupported opcode was received; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, miso=0, miso_oe=0, busy=0, err_opcode=0, bit counter=0, address=0, synchronisers cleared to cs_n=1, sclk=0, mosi=0. Memory contents are not reset.
- Sampling: cs_n, sclk and mosi pass through SYNC_STAGES flops. rise/fall = edge of the synchronised sclk. All decisions use the synchronised values.
- Latency from a pin edge to its internal effect is SYNC_STAGES+1 clk.
- Shift rule (mode 0): mosi is sampled MSB-first on each sclk rise. miso is updated on each sclk fall.
- State IDLE: entered while cs_n=1. The falling edge of synchronised cs_n goes to CMD with bit counter=0.
- State CMD: collects 8 bits.
  - 0x03 goes to ADDR_HI with op=READ.
  - 0x02 goes to ADDR_HI with op=WRITE.
  - Any other value goes to IGNORE and sets err_opcode.
- State ADDR_HI: collects 8 bits (address[15:8]), then goes to ADDR_LO.
- State ADDR_LO: collects 8 bits (address[7:0]). Then:
  - READ: latch mem[address[ADDR_BITS-1:0]] into the tx shifter and go to DATA_RD.
  - WRITE: go to DATA_WR.
- State DATA_RD:
  - miso_oe=1.
  - bit7 of the tx byte appears on miso at the sclk fall that ends the last address bit. This puts it before the first data rise.
  - Each subsequent fall shifts the next bit out.
  - After the 8th data bit has been presented and its fall occurs, the address increments, mem[new address] is loaded and its bit7 is driven. The read stream is continuous with no gap byte.
- State DATA_WR:
  - After each 8th rise, mem[address] is written with the assembled byte and the address increments.
  - A partial byte at cs_n rise is discarded; memory is untouched.
- State IGNORE: miso_oe=0 and mosi is discarded until cs_n rises.
- Address wrap: the increment is modulo 2^ADDR_BITS. 0xFF+1 becomes 0x00 for ADDR_BITS=8.
- cs_n rise in any state, including mid-byte: go to IDLE within SYNC_STAGES+1 clk. miso_oe=0, miso=0, bit counter cleared, any pending partial write dropped.
- miso_oe is 0 in every state except DATA_RD. When miso_oe=0, miso=0, so the line can be ORed or wired directly.
- Load port:
  - load_en=1 writes load_data to mem[load_addr] on that clk edge, only while state=IDLE.
  - It is ignored otherwise, and an SPI transaction always has priority.
- A simultaneous cs_n fall and load_en in IDLE: the load completes, then the transaction proceeds normally.
- Reset mid-transaction: everything returns to reset values immediately. Memory retains all completed byte writes.

Test Plan:
- Preload mem[0x10..0x12] = 0xA5, 0x3C, 0x7E via the load port. SPI 03 00 10, then clock 24 bits. miso returns A5 3C 7E MSB-first, and miso_oe=1 only during the data bits.
- SPI 02 00 FE with data 11 22 33, then 03 00 FE reading 3 bytes. Expect 11 22 33, and mem[0x00]=0x33 (wrap).
- SPI 02 00 20, then 0xC3 followed by 4 bits of 0xF, then cs_n rise. mem[0x20]=0xC3 and mem[0x21] is unchanged.
- Opcode 0x05: err_opcode=1, miso_oe stays 0 for the whole frame. A following 03 read still works.
- Deassert rst_n mid-DATA_RD (bit 3 of byte 2). miso=0, miso_oe=0, busy=0 immediately. A subsequent read shows preloaded memory intact.
- load_en pulsed during an active WRITE to 0x40 with load_addr=0x40. The SPI data byte is retained and the load is ignored.
